// File: rtl/alu_instr_sequencer_pkg.sv
// Shared types and constants for the ALU instruction sequencer:
// FSM state encoding, opcode and ALU CONTROL constants, opcode decode,
// and the per-state strobe pattern.
package alu_instr_sequencer_pkg;

    localparam int OPW   = 5;
    localparam int CTRLW = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_FAULT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB = 5'b00100;
    localparam logic [OPW-1:0] OP_ROR = 5'b00111;

    localparam logic [CTRLW-1:0] ALU_ADD = 5'b00000;
    localparam logic [CTRLW-1:0] ALU_SUB = 5'b00001;
    localparam logic [CTRLW-1:0] ALU_ROR = 5'b00110;

    typedef struct packed {
        logic             legal;
        logic [CTRLW-1:0] control;
    } decode_t;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic zlo_in;
        logic zlo_out;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic busy;
    } strobes_t;

    // Opcode to ALU CONTROL mapping; anything outside the three supported
    // instructions comes back with legal cleared and CONTROL zero.
    function automatic decode_t decode_opcode(input logic [OPW-1:0] op);
        decode_t d;
        d.legal   = 1'b1;
        d.control = '0;
        case (op)
            OP_ADD:  d.control = ALU_ADD;
            OP_SUB:  d.control = ALU_SUB;
            OP_ROR:  d.control = ALU_ROR;
            default: d.legal   = 1'b0;
        endcase
        return d;
    endfunction

    // Datapath strobes asserted while the FSM sits in a given state.
    function automatic strobes_t strobes_for(input state_t s);
        strobes_t st;
        st = '0;
        case (s)
            ST_T0: begin
                st.pc_out = 1'b1; st.mar_in = 1'b1; st.inc_pc = 1'b1; st.zlo_in = 1'b1;
                st.busy = 1'b1;
            end
            ST_T1: begin
                st.zlo_out = 1'b1; st.pc_in = 1'b1; st.read = 1'b1; st.mdr_in = 1'b1;
                st.busy = 1'b1;
            end
            ST_T2: begin
                st.mdr_out = 1'b1; st.ir_in = 1'b1; st.busy = 1'b1;
            end
            ST_T3: begin
                st.grb = 1'b1; st.r_out = 1'b1; st.y_in = 1'b1; st.busy = 1'b1;
            end
            ST_T4: begin
                st.grc = 1'b1; st.r_out = 1'b1; st.zlo_in = 1'b1; st.busy = 1'b1;
            end
            ST_T5: begin
                st.zlo_out = 1'b1; st.gra = 1'b1; st.r_in = 1'b1; st.busy = 1'b1;
            end
            default: st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the sequencer (master) and the Datapath /
// select-and-encode side (slave). Step exists only when SINGLE_STEP_EN is defined.
interface alu_instr_sequencer_if;
    import alu_instr_sequencer_pkg::*;

`ifdef SINGLE_STEP_EN
    logic             Step;
`endif
    logic             Run;
    logic             Stop;
    logic [OPW-1:0]   IR_Opcode;
    logic             Mem_Ready;

    logic PC_Out, MAR_In, IncPC, ZLO_In, ZLO_Out, PC_In, Read, MDR_In, MDR_Out, IR_In, Y_In;
    logic Gra, Grb, Grc, R_In, R_Out;
    logic [CTRLW-1:0] CONTROL;
    logic             Busy;
    logic             Illegal;
    logic             Mem_Err;

    modport master (
`ifdef SINGLE_STEP_EN
        input  Step,
`endif
        input  Run, Stop, IR_Opcode, Mem_Ready,
        output PC_Out, MAR_In, IncPC, ZLO_In, ZLO_Out, PC_In, Read, MDR_In, MDR_Out,
               IR_In, Y_In, Gra, Grb, Grc, R_In, R_Out, CONTROL, Busy, Illegal, Mem_Err
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        output Step,
`endif
        output Run, Stop, IR_Opcode, Mem_Ready,
        input  PC_Out, MAR_In, IncPC, ZLO_In, ZLO_Out, PC_In, Read, MDR_In, MDR_Out,
               IR_In, Y_In, Gra, Grb, Grc, R_In, R_Out, CONTROL, Busy, Illegal, Mem_Err
    );

endinterface

// File: rtl/alu_instr_sequencer_mem_wait_timer.sv
// Counts consecutive not-ready cycles of the T1 memory handshake and flags
// the cycle on which the MEM_TIMEOUT-th wait happens.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    logic [7:0] count;

    // Count only while waiting in T1; any ready cycle or leaving T1 restarts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (active && !mem_ready) begin
            count <= count + 8'd1;
        end else begin
            count <= '0;
        end
    end

    assign expired = active && !mem_ready && (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired T0..T5 control-step sequencer for three-register ALU
// instructions (add, sub, ror). Outputs are registered and follow the state.
// Optional build macro: SINGLE_STEP_EN adds a Step input; each rising edge of
// Step (with Run high, Stop low) runs exactly one instruction.
module alu_instr_sequencer
    import alu_instr_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  Clock,
    input  logic                  Clear,
    alu_instr_sequencer_if.master bus
);

    state_t           state;
    state_t           next_state;
    strobes_t         strobes;
    logic [CTRLW-1:0] control;
    logic             illegal;
    logic             mem_err;
    logic             expired;
    logic             step_ok;
    decode_t          dec;

    assign dec = decode_opcode(bus.IR_Opcode);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (Clock),
        .rst       (Clear),
        .active    (state == ST_T1),
        .mem_ready (bus.Mem_Ready),
        .expired   (expired)
    );

`ifdef SINGLE_STEP_EN
    logic step_q;

    // Remember last Step level so only a fresh rising edge launches an instruction.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.Step;
        end
    end

    assign step_ok = bus.Step && !step_q;
`else
    assign step_ok = 1'b1;
`endif

    // Next-state rules; Run/Stop matter only in IDLE and T5.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.Run && !bus.Stop && step_ok) next_state = ST_T0;
            ST_T0:    next_state = ST_T1;
            ST_T1: begin
                if (bus.Mem_Ready)  next_state = ST_T2;
                else if (expired)   next_state = ST_FAULT;
            end
            ST_T2:    next_state = ST_T3;
            ST_T3:    next_state = dec.legal ? ST_T4 : ST_FAULT;
            ST_T4:    next_state = ST_T5;
`ifdef SINGLE_STEP_EN
            ST_T5:    next_state = ST_IDLE;
`else
            ST_T5:    next_state = (bus.Run && !bus.Stop) ? ST_T0 : ST_IDLE;
`endif
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State plus registered Moore outputs, so strobes change in the same cycle as the state.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state   <= ST_IDLE;
            strobes <= '0;
            control <= '0;
            illegal <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state   <= next_state;
            strobes <= strobes_for(next_state);
            control <= (next_state == ST_T4) ? dec.control : '0;
            if (state == ST_T3 && !dec.legal) illegal <= 1'b1;
            if (state == ST_T1 && !bus.Mem_Ready && expired) mem_err <= 1'b1;
        end
    end

    assign bus.PC_Out  = strobes.pc_out;
    assign bus.MAR_In  = strobes.mar_in;
    assign bus.IncPC   = strobes.inc_pc;
    assign bus.ZLO_In  = strobes.zlo_in;
    assign bus.ZLO_Out = strobes.zlo_out;
    assign bus.PC_In   = strobes.pc_in;
    assign bus.Read    = strobes.read;
    assign bus.MDR_In  = strobes.mdr_in;
    assign bus.MDR_Out = strobes.mdr_out;
    assign bus.IR_In   = strobes.ir_in;
    assign bus.Y_In    = strobes.y_in;
    assign bus.Gra     = strobes.gra;
    assign bus.Grb     = strobes.grb;
    assign bus.Grc     = strobes.grc;
    assign bus.R_In    = strobes.r_in;
    assign bus.R_Out   = strobes.r_out;
    assign bus.Busy    = strobes.busy;
    assign bus.CONTROL = control;
    assign bus.Illegal = illegal;
    assign bus.Mem_Err = mem_err;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Testbench for alu_instr_sequencer: an instruction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
// Honours SINGLE_STEP_EN in the same way as the design.
module tb_alu_instr_sequencer;
    import alu_instr_sequencer_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    bit   cmp_en = 1'b0;

    // Model: -1 idle, 0..5 control step, 6 fault
    int          m_phase = -1;
    int          m_wait  = 0;
    int          m_ctrl  = 0;
    bit          m_illegal = 1'b0;
    bit          m_memerr  = 1'b0;
    logic        m_step_prev = 1'b0;

    alu_instr_sequencer_if bus_if ();

    alu_instr_sequencer #(.MEM_TIMEOUT(15)) dut (
        .Clock (clk),
        .Clear (clr),
        .bus   (bus_if.master)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [16:0] dut_vec();
        return {bus_if.PC_Out, bus_if.MAR_In, bus_if.IncPC, bus_if.ZLO_In, bus_if.ZLO_Out,
                bus_if.PC_In, bus_if.Read, bus_if.MDR_In, bus_if.MDR_Out, bus_if.IR_In,
                bus_if.Y_In, bus_if.Gra, bus_if.Grb, bus_if.Grc, bus_if.R_In, bus_if.R_Out,
                bus_if.Busy};
    endfunction

    // Which strobes each control step raises, straight from the step table
    function automatic logic [16:0] exp_vec(input int ph);
        logic pc_out, mar_in, inc_pc, zlo_in, zlo_out, pc_in, rd, mdr_in, mdr_out;
        logic ir_in, y_in, gra, grb, grc, r_in, r_out, busy;
        {pc_out, mar_in, inc_pc, zlo_in, zlo_out, pc_in, rd, mdr_in, mdr_out} = '0;
        {ir_in, y_in, gra, grb, grc, r_in, r_out, busy} = '0;
        case (ph)
            0: begin pc_out = 1; mar_in = 1; inc_pc = 1; zlo_in = 1; busy = 1; end
            1: begin zlo_out = 1; pc_in = 1; rd = 1; mdr_in = 1; busy = 1; end
            2: begin mdr_out = 1; ir_in = 1; busy = 1; end
            3: begin grb = 1; r_out = 1; y_in = 1; busy = 1; end
            4: begin grc = 1; r_out = 1; zlo_in = 1; busy = 1; end
            5: begin zlo_out = 1; gra = 1; r_in = 1; busy = 1; end
            default: ;
        endcase
        return {pc_out, mar_in, inc_pc, zlo_in, zlo_out, pc_in, rd, mdr_in, mdr_out,
                ir_in, y_in, gra, grb, grc, r_in, r_out, busy};
    endfunction

    function automatic int model_map(input logic [4:0] op);
        case (op)
            5'd3:    return 0;
            5'd4:    return 1;
            5'd7:    return 6;
            default: return -1;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected,
                     $time);
        end
    endtask

    task automatic apply_stimulus(input logic run, input logic stop, input logic ready,
                                  input logic [4:0] op);
        bus_if.Run       = run;
        bus_if.Stop      = stop;
        bus_if.Mem_Ready = ready;
        bus_if.IR_Opcode = op;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_output("clear_strobes", 32'(dut_vec()), 32'd0);
        check_output("clear_control", 32'(bus_if.CONTROL), 32'd0);
        check_output("clear_sticky", {30'd0, bus_if.Illegal, bus_if.Mem_Err}, 32'd0);
        bus_if.Run = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Reference model: advances one control step per clock from the instruction rules
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_phase = -1; m_wait = 0; m_ctrl = 0; m_illegal = 0; m_memerr = 0;
            m_step_prev = 1'b0;
        end else begin
            bit go;
            int r;
            go = bus_if.Run && !bus_if.Stop;
`ifdef SINGLE_STEP_EN
            go = go && bus_if.Step && !m_step_prev;
            m_step_prev = bus_if.Step;
`endif
            case (m_phase)
                -1: if (go) m_phase = 0;
                0:  m_phase = 1;
                1: begin
                    if (bus_if.Mem_Ready) begin
                        m_phase = 2; m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == 15) begin m_phase = 6; m_memerr = 1; m_wait = 0; end
                    end
                end
                2:  m_phase = 3;
                3: begin
                    r = model_map(bus_if.IR_Opcode);
                    if (r < 0) begin m_phase = 6; m_illegal = 1; end
                    else begin m_phase = 4; m_ctrl = r; end
                end
                4:  m_phase = 5;
`ifdef SINGLE_STEP_EN
                5:  m_phase = -1;
`else
                5:  m_phase = go ? 0 : -1;
`endif
                default: m_phase = 6;
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model, 2 units after the edge
    always begin
        @(posedge clk);
        #2;
        if (cmp_en && !clr) begin
            check_output("model_strobes", 32'(dut_vec()), 32'(exp_vec(m_phase)));
            check_output("model_control", 32'(bus_if.CONTROL), (m_phase == 4) ? m_ctrl : 0);
            check_output("model_illegal", 32'(bus_if.Illegal), 32'(m_illegal));
            check_output("model_mem_err", 32'(bus_if.Mem_Err), 32'(m_memerr));
        end
    end

    // Safety net so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int reads;
        int t0_count;
        int first_t0;
        int second_t0;
        bit seen_ir;
        bit saw_t4;

        apply_stimulus(1'b0, 1'b0, 1'b1, 5'd0);
`ifdef SINGLE_STEP_EN
        bus_if.Step = 1'b0;
`endif
        #2 clr = 1'b1;
        @(negedge clk);
        check_output("reset_strobes", 32'(dut_vec()), 32'd0);
        check_output("reset_flags", {30'd0, bus_if.Illegal, bus_if.Mem_Err}, 32'd0);
        clr = 1'b0;
        cmp_en = 1'b1;

`ifndef SINGLE_STEP_EN
        // ror with no memory wait; Stop raised during T2 ends after this instruction
        apply_stimulus(1'b1, 1'b0, 1'b1, 5'b00111);
        tick(1);
        check_output("t0_pc_out_busy", {30'd0, bus_if.PC_Out, bus_if.Busy}, 32'd3);
        tick(1);
        check_output("t1_read", 32'(bus_if.Read), 32'd1);
        tick(1);
        check_output("t2_ir_in", 32'(bus_if.IR_In), 32'd1);
        bus_if.Stop = 1'b1;
        tick(2);
        check_output("t4_control_ror", 32'(bus_if.CONTROL), 32'h06);
        tick(1);
        check_output("t5_gra_rin", {30'd0, bus_if.Gra, bus_if.R_In}, 32'd3);
        check_output("t5_control_zero", 32'(bus_if.CONTROL), 32'd0);
        tick(1);
        check_output("stop_idle_busy", 32'(bus_if.Busy), 32'd0);

        // add with three wait cycles in T1
        apply_stimulus(1'b1, 1'b0, 1'b0, 5'b00011);
        reads = 0;
        seen_ir = 0;
        for (int i = 0; i < 30 && !seen_ir; i++) begin
            tick(1);
            if (bus_if.Read) reads++;
            if (bus_if.IR_In) seen_ir = 1;
            if (reads == 4) begin bus_if.Mem_Ready = 1'b1; bus_if.Stop = 1'b1; end
        end
        check_output("wait_reached_t2", 32'(seen_ir), 32'd1);
        check_output("wait_read_cycles", 32'(reads), 32'd4);
        tick(4);
        check_output("wait_done_idle", {30'd0, bus_if.Busy, bus_if.Mem_Err}, 32'd0);

        // back-to-back instructions while Run stays high
        apply_stimulus(1'b1, 1'b0, 1'b1, 5'b00100);
        t0_count = 0; first_t0 = -1; second_t0 = -1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus_if.PC_Out) begin
                t0_count++;
                if (t0_count == 1) first_t0 = i;
                else if (t0_count == 2) begin second_t0 = i; bus_if.Stop = 1'b1; end
            end
        end
        check_output("b2b_instr_count", 32'(t0_count), 32'd2);
        check_output("b2b_spacing", 32'(second_t0 - first_t0), 32'd6);
        check_output("b2b_idle", 32'(bus_if.Busy), 32'd0);

        // memory never ready: fault after 15 T1 cycles
        apply_stimulus(1'b1, 1'b0, 1'b0, 5'b00011);
        reads = 0;
        for (int i = 0; i < 40 && !bus_if.Mem_Err; i++) begin
            tick(1);
            if (bus_if.Read) reads++;
        end
        check_output("timeout_read_cycles", 32'(reads), 32'd15);
        check_output("timeout_mem_err", 32'(bus_if.Mem_Err), 32'd1);
        tick(3);
        check_output("fault_strobes_zero", 32'(dut_vec()), 32'd0);
        check_output("fault_mem_err_sticky", 32'(bus_if.Mem_Err), 32'd1);
        do_clear();

        // illegal opcode: fault after T3, T4 never reached
        apply_stimulus(1'b1, 1'b0, 1'b1, 5'b11111);
        saw_t4 = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus_if.Grc || bus_if.CONTROL != 5'd0) saw_t4 = 1;
        end
        check_output("illegal_flag", 32'(bus_if.Illegal), 32'd1);
        check_output("illegal_no_t4", 32'(saw_t4), 32'd0);
        check_output("illegal_not_busy", 32'(bus_if.Busy), 32'd0);
        do_clear();

        // sub aborted by Clear during T4
        apply_stimulus(1'b1, 1'b0, 1'b1, 5'b00100);
        tick(5);
        check_output("t4_control_sub", 32'(bus_if.CONTROL), 32'h01);
        do_clear();
        tick(2);
        check_output("after_abort_idle", 32'(bus_if.Busy), 32'd0);
`else
        // single step: nothing happens without a Step edge
        apply_stimulus(1'b1, 1'b0, 1'b1, 5'b00111);
        tick(4);
        check_output("step_wait_idle", 32'(bus_if.Busy), 32'd0);
        t0_count = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || i == 12) bus_if.Step = 1'b1;
            if (i == 3 || i == 14) bus_if.Step = 1'b0;
            tick(1);
            if (bus_if.PC_Out) t0_count++;
            if (i == 10) check_output("step_idle_between", 32'(bus_if.Busy), 32'd0);
        end
        check_output("step_instr_count", 32'(t0_count), 32'd2);
        check_output("step_end_idle", 32'(bus_if.Busy), 32'd0);
`endif

        cmp_en = 1'b0;
        tick(1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
